// File: rtl/dot_mac_seq_if.sv
// Register-file read port and result handshake of the sequencing dot-product engine.
// master = engine side, slave = register file / result consumer side.
interface dot_mac_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(LANES * DEPTH)
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                      rf_enable;
  logic [IDX_W-1:0]          rf_idx;
  logic [LANES*DATA_W-1:0]   x_in;
  logic [LANES*DATA_W-1:0]   w_in;
  logic [ACC_W-1:0]          result;
  logic                      result_valid;
  logic                      result_ready;

  modport master (
    output rf_enable, rf_idx, result, result_valid,
    input  x_in, w_in, result_ready
  );

  modport slave (
    input  rf_enable, rf_idx, result, result_valid,
    output x_in, w_in, result_ready
  );
endinterface

// File: rtl/dot_mac_seq.sv
// Sequencing signed dot-product engine: walks DEPTH register-file rows, multiplies LANES pairs
// per row in a registered stage and accumulates. Optional DOT_MAC_RELU_EN clamps negative results to 0.
module dot_mac_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(LANES * DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  dot_mac_seq_if.master  bus
);
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state;
  logic                      rf_en_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      drain_q;
  logic                      rd_vld_q;
  logic                      p_vld_q;
  logic                      busy_q;
  logic                      res_vld_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   res_q;
  logic signed [ACC_W-1:0]   acc_next_c;
  logic signed [PROD_W-1:0]  prod_c [LANES];
  logic signed [PROD_W-1:0]  prod_q [LANES];

  // Per-lane full-precision signed products of the row returned by the register file
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_c[l] = PROD_W'($signed(bus.x_in[l*DATA_W +: DATA_W]))
                * PROD_W'($signed(bus.w_in[l*DATA_W +: DATA_W]));
    end
  end

  // Lane sum added to the running accumulator; wraps modulo 2^ACC_W if ACC_W is narrowed
  always_comb begin
    acc_next_c = acc_q;
    for (int l = 0; l < LANES; l++) begin
      acc_next_c = acc_next_c + ACC_W'(prod_q[l]);
    end
  end

  // Stage 1: read-data valid tracks rf_enable one cycle late, products register behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      p_vld_q  <= 1'b0;
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
    end else begin
      rd_vld_q <= rf_en_q;
      p_vld_q  <= rd_vld_q;
      if (rd_vld_q) begin
        for (int l = 0; l < LANES; l++) prod_q[l] <= prod_c[l];
      end
    end
  end

  // Sequencer, stage 2 accumulation and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rf_en_q   <= 1'b0;
      idx_q     <= '0;
      drain_q   <= 1'b0;
      busy_q    <= 1'b0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      if (p_vld_q) acc_q <= acc_next_c;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            acc_q   <= '0;
            rf_en_q <= 1'b1;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (idx_q == IDX_W'(DEPTH - 1)) begin
            state   <= DRAIN;
            rf_en_q <= 1'b0;
            idx_q   <= '0;
            drain_q <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          // Second drain cycle: the last row's products land in acc_next_c now
          if (drain_q) begin
            state     <= DONE;
            res_vld_q <= 1'b1;
`ifdef DOT_MAC_RELU_EN
            res_q     <= acc_next_c[ACC_W-1] ? '0 : acc_next_c;
`else
            res_q     <= acc_next_c;
`endif
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state     <= IDLE;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign bus.rf_enable    = rf_en_q;
  assign bus.rf_idx       = idx_q;
  assign bus.result       = res_q;
  assign bus.result_valid = res_vld_q;
endmodule

// File: tb/tb_dot_mac_seq.sv
// Randomized bench for dot_mac_seq: a 1-cycle-latency register file model feeds rows,
// expected results come from a plain sum-of-products model.
module tb_dot_mac_seq;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(LANES * DEPTH);
  localparam int unsigned ROW_W  = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;

  dot_mac_seq_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ACC_W(ACC_W)) bus ();

  dot_mac_seq #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int xm [DEPTH][LANES];
  int wm [DEPTH][LANES];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < DEPTH; r++) begin
      for (int l = 0; l < LANES; l++) begin
        case (mode)
          0: begin xm[r][l] = 1;    wm[r][l] = 1;    end
          1: begin xm[r][l] = -128; wm[r][l] = -128; end
          2: begin xm[r][l] = r;    wm[r][l] = 1;    end
          3: begin xm[r][l] = 1;    wm[r][l] = -1;   end
          default: begin
            xm[r][l] = int'($urandom_range(255)) - 128;
            wm[r][l] = int'($urandom_range(255)) - 128;
          end
        endcase
      end
    end
  endtask

  function automatic longint model();
    longint s = 0;
    logic signed [ACC_W-1:0] t;
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < LANES; l++)
        s += longint'(xm[r][l]) * longint'(wm[r][l]);
    t = ACC_W'(s);
`ifdef DOT_MAC_RELU_EN
    if (t < 0) t = '0;
`endif
    return longint'(t);
  endfunction

  function automatic logic [ROW_W-1:0] pack_row(input int r, input bit is_w);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++)
      v[l*DATA_W +: DATA_W] = DATA_W'(is_w ? wm[r][l] : xm[r][l]);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      longint'(busy), 0);
    check({tag, "_rf_enable"}, longint'(bus.rf_enable), 0);
    check({tag, "_rf_idx"},    longint'(bus.rf_idx), 0);
    check({tag, "_result"},    longint'(bus.result), 0);
    check({tag, "_valid"},     longint'(bus.result_valid), 0);
  endtask

  // One full operation; called #1 after an edge with the DUT in IDLE. Ends in the
  // mandatory IDLE cycle so a following call tests back-to-back throughput.
  task automatic run_op(input int hold, input bit inject, input int abort_at);
    longint exp;
    bit     pe;
    int     pi;
    int     last;
    exp  = model();
    pe   = 1'b0;
    pi   = 0;
    last = DEPTH + 4 + hold;
    start = 1'b1;
    bus.result_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= last; c++) begin
      if (pe) begin
        bus.x_in = pack_row(pi, 1'b0);
        bus.w_in = pack_row(pi, 1'b1);
      end else begin
        bus.x_in = ROW_W'($urandom);
        bus.w_in = ROW_W'($urandom);
      end
      bus.result_ready = (c >= DEPTH + 3 + hold);
      start = inject && (c == 3 || c == DEPTH + 3);
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("rf_enable", longint'(bus.rf_enable), longint'(c <= DEPTH));
      check("rf_idx", longint'(bus.rf_idx), (c <= DEPTH) ? longint'(c - 1) : 0);
      check("busy", longint'(busy), longint'(c < last));
      check("result_valid", longint'(bus.result_valid),
            longint'(c >= DEPTH + 3 && c <= DEPTH + 3 + hold));
      if (c >= DEPTH + 3 && c <= DEPTH + 3 + hold)
        check("result", longint'($signed(bus.result)), exp);
      pe = bus.rf_enable;
      pi = int'(bus.rf_idx);
      if (c < last) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bus.result_ready = 1'b0;
    bus.x_in = '0;
    bus.w_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fill(0); run_op(0, 1'b0, 0);
    fill(1); run_op(0, 1'b0, 0);
    fill(2); run_op(0, 1'b0, 0);
    fill(3); run_op(0, 1'b0, 0);
    fill(0); run_op(5, 1'b1, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("idle_after_ignored_start", longint'(busy), 0);
      check("idle_valid", longint'(bus.result_valid), 0);
    end

    fill(0); run_op(0, 1'b0, 5);
    @(posedge clk); #1;
    check_reset_outputs("post_abort");
    fill(0); run_op(0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      fill(4);
      run_op(int'($urandom_range(3)), 1'($urandom_range(1)), 0);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
